wb_splitter_n: RTL and testbench
================================

# wb_splitter_n

Parametrised, registered Wishbone classic bus splitter connecting one master port to NUM_SLAVES equally sized, contiguous slave windows. It generalises the fixed three-slave combinational splitter: slave count and window geometry are parameters, the response path is registered, and unmapped or hung accesses are terminated with an error word instead of stalling the master. It sits between the user-project wrapper's Wishbone port and the peripheral instances.

## Interface
- NUM_SLAVES, 4, number of slave windows (1..16)
- BASE_ADDR, 32'h3000_0000, start of window 0
- SLAVE_ADDR_SIZE, 32'h0001_0000, window size in bytes; power of two; window i starts at BASE_ADDR + i*SLAVE_ADDR_SIZE
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without slave ack (1..65535)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error termination

- wb_clk  in  1  bus clock; all state on rising edge
- wb_rst  in  1  reset, asynchronous, active-high
- wb_adr / wb_dat_i / wb_sel / wb_we  in  32/32/4/1  master request
- wb_stb, wb_cyc  in  1 each  master strobe / cycle
- wb_dat_o  out  32  registered read data to master
- wb_ack  out  1  registered acknowledge, one-cycle pulse
- s_adr / s_dat_o / s_sel / s_we  out  32/32/4/1  request broadcast to all slaves (from latched request)
- s_stb, s_cyc  out  NUM_SLAVES  per-slave strobe/cycle, one-hot or zero
- s_dat_i  in  32*NUM_SLAVES  slave read data, slave i at [32*i+31:32*i]
- s_ack  in  NUM_SLAVES  slave acknowledges
- err_pulse  out  1  one-cycle pulse on any error termination
- err_adr  out  32  address of most recent error termination

## Operation
- FSM states IDLE, BUSY, RESP. Reset: IDLE; wb_ack, s_stb, s_cyc, err_pulse = 0; wb_dat_o, err_adr, s_adr, s_dat_o, s_sel, s_we = 0.
- IDLE: on wb_cyc & wb_stb, latch adr/dat/sel/we. Index = (wb_adr − BASE_ADDR) >> log2(SLAVE_ADDR_SIZE). Mapped iff wb_adr ≥ BASE_ADDR and index < NUM_SLAVES (subtraction 32-bit unsigned; addresses below BASE_ADDR must not wrap into a window).
  - Mapped: assert s_cyc[index], s_stb[index]; clear timeout counter; → BUSY.
  - Unmapped: wb_dat_o = ERR_DATA, err_adr = wb_adr, err_pulse = 1; → RESP.
- BUSY: only s_ack[index] is observed; other acks ignored.
  - s_ack[index] = 1: wb_dat_o = slave data (reads; writes also capture it, value don't-care), drop s_stb/s_cyc; → RESP.
  - wb_cyc = 0 (master abort): drop s_stb/s_cyc; → IDLE; no wb_ack, no error.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop s_stb/s_cyc; wb_dat_o = ERR_DATA, err_adr = latched address, err_pulse = 1; → RESP.
  - Ack and timeout in the same cycle: ack wins.
- RESP: wb_ack = 1 for exactly this cycle; → IDLE. A new request is not sampled in RESP; IDLE is entered with the master's strobe expected low.
- Write data on error termination is discarded; no slave sees a strobe for unmapped addresses.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous); no ack is issued.

## Timing
- Request sampled at edge E0 → s_stb high after E0.
- Zero-wait slave (combinational ack): ack sampled at E1, wb_ack high E1–E2. Minimum latency: 2 edges request-to-ack end; throughput one transfer per 3 cycles.
- Slave with k wait cycles: wb_ack high from E(1+k) for one cycle.
- Unmapped: wb_ack high E1–E2, err_pulse coincident with the transition into RESP (high E0–E1).
- Timeout: err_pulse and termination at the edge where the counter equals TIMEOUT_CYCLES; wb_ack one cycle later.

## Configuration
- WB_SPLITTER_TIMEOUT_EN defined: timeout counter (width clog2(TIMEOUT_CYCLES+1)) and timeout termination present as above.
- Not defined: no counter; BUSY waits indefinitely for ack or master abort; only unmapped accesses produce err_pulse.

## Test plan
- Read window 2 (wb_adr 32'h3002_0010), slave 2 acks with 32'h1234_5678 after 3 waits → s_stb[2] only, wb_dat_o = 32'h1234_5678, one-cycle wb_ack, err_pulse never high.
- Write window 0 at 32'h3000_0004, data 32'hA5A5_0001, sel 4'b0011 → s_adr/s_dat_o/s_sel/s_we match, s_stb[0] until ack, single wb_ack.
- Unmapped 32'h3004_0000 and 32'h2FFF_FFFC (NUM_SLAVES=4) → no s_stb, wb_ack with 32'hDEAD_BEEF, err_pulse once each, err_adr matches.
- Timeout enabled, TIMEOUT_CYCLES=8, slave 1 never acks → s_stb[1] dropped after 8 BUSY cycles, wb_ack with ERR_DATA, err_adr = 32'h3001_0000; macro undefined → no ack after 1000 cycles.
- Master drops wb_cyc in BUSY, then issues a new read to window 3 → no ack for the aborted access, new access completes normally; spurious s_ack[0] during it is ignored.
- Assert wb_rst mid-BUSY → s_stb, wb_ack, err_pulse low immediately; next request after release completes normally.

Source files
------------

// File: rtl/wb_splitter_n.sv
// Registered Wishbone classic splitter: one master, NUM_SLAVES equal contiguous windows.
// Define WB_SPLITTER_TIMEOUT_EN to add the BUSY-state timeout termination.
module wb_splitter_n #(
    parameter int unsigned NUM_SLAVES      = 4,
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter logic [31:0] SLAVE_ADDR_SIZE = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic [31:0]               wb_adr,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel,
    input  logic                      wb_we,
    input  logic                      wb_stb,
    input  logic                      wb_cyc,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack,
    output logic [31:0]               s_adr,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel,
    output logic                      s_we,
    output logic [NUM_SLAVES-1:0]     s_stb,
    output logic [NUM_SLAVES-1:0]     s_cyc,
    input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]     s_ack,
    output logic                      err_pulse,
    output logic [31:0]               err_adr
);

    localparam int unsigned WIN_SHIFT = $clog2(SLAVE_ADDR_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    hold_q, hold_d;
    logic [31:0]             adr_q, adr_d;
    logic [31:0]             dat_q, dat_d;
    logic [3:0]              sel_q, sel_d;
    logic                    we_q, we_d;
    logic [NUM_SLAVES-1:0]   slv_q, slv_d;
    logic [31:0]             rdat_q, rdat_d;
    logic                    ack_q, ack_d;
    logic                    errp_q, errp_d;
    logic [31:0]             erradr_q, erradr_d;

    logic [31:0]             win_off;
    logic [31:0]             win_idx;
    logic                    mapped;
    logic [NUM_SLAVES-1:0]   win_onehot;
    logic                    slave_ack;
    logic [31:0]             slave_rdata;
    logic                    timeout;

    // Address decode: addresses below BASE_ADDR are rejected before the offset can wrap.
    assign win_off = wb_adr - BASE_ADDR;
    assign win_idx = win_off >> WIN_SHIFT;
    assign mapped  = (wb_adr >= BASE_ADDR) && (win_idx < NUM_SLAVES);

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            win_onehot[i] = (win_idx == 32'(i));
        end
    end

    // Only the strobed slave's ack and data are visible; all others are masked off.
    assign slave_ack = |(s_ack & slv_q);

    always_comb begin
        slave_rdata = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (slv_q[i]) begin
                slave_rdata = s_dat_i[32*i +: 32];
            end
        end
    end

`ifdef WB_SPLITTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds the number of completed BUSY cycles; it fires on the last allowed one.
    assign timeout = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == BUSY && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Error terminations spend two cycles in RESP: err_pulse first, then wb_ack (hold_q marks the first).
    always_comb begin
        state_d  = state_q;
        hold_d   = 1'b0;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        slv_d    = slv_q;
        rdat_d   = rdat_q;
        ack_d    = 1'b0;
        errp_d   = 1'b0;
        erradr_d = erradr_q;

        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    adr_d = wb_adr;
                    dat_d = wb_dat_i;
                    sel_d = wb_sel;
                    we_d  = wb_we;
                    if (mapped) begin
                        slv_d   = win_onehot;
                        state_d = BUSY;
                    end else begin
                        rdat_d   = ERR_DATA;
                        erradr_d = wb_adr;
                        errp_d   = 1'b1;
                        hold_d   = 1'b1;
                        state_d  = RESP;
                    end
                end
            end

            BUSY: begin
                if (!wb_cyc) begin
                    slv_d   = '0;
                    state_d = IDLE;
                end else if (slave_ack) begin
                    rdat_d  = slave_rdata;
                    slv_d   = '0;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else if (timeout) begin
                    slv_d    = '0;
                    rdat_d   = ERR_DATA;
                    erradr_d = adr_q;
                    errp_d   = 1'b1;
                    hold_d   = 1'b1;
                    state_d  = RESP;
                end
            end

            RESP: begin
                if (hold_q) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= IDLE;
            hold_q   <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            slv_q    <= '0;
            rdat_q   <= '0;
            ack_q    <= 1'b0;
            errp_q   <= 1'b0;
            erradr_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            slv_q    <= slv_d;
            rdat_q   <= rdat_d;
            ack_q    <= ack_d;
            errp_q   <= errp_d;
            erradr_q <= erradr_d;
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack    = ack_q;
    assign s_adr     = adr_q;
    assign s_dat_o   = dat_q;
    assign s_sel     = sel_q;
    assign s_we      = we_q;
    assign s_stb     = slv_q;
    assign s_cyc     = slv_q;
    assign err_pulse = errp_q;
    assign err_adr   = erradr_q;

endmodule

// File: tb/tb_wb_splitter_n.sv
// Self-checking bench for wb_splitter_n: vector table plus hand-written abort, hang and reset sequences.
// Timeout checks follow WB_SPLITTER_TIMEOUT_EN exactly as the design does.
module tb_wb_splitter_n;

    localparam int NSLV    = 4;
    localparam int TIMEOUT = 8;

    logic               clk;
    logic               rst;
    logic [31:0]        wbAdr;
    logic [31:0]        wbDatI;
    logic [3:0]         wbSel;
    logic               wbWe;
    logic               wbStb;
    logic               wbCyc;
    logic [31:0]        wbDatO;
    logic               wbAck;
    logic [31:0]        sAdr;
    logic [31:0]        sDatO;
    logic [3:0]         sSel;
    logic               sWe;
    logic [NSLV-1:0]    sStb;
    logic [NSLV-1:0]    sCyc;
    logic [32*NSLV-1:0] sDatI;
    logic [NSLV-1:0]    sAck;
    logic               errPulse;
    logic [31:0]        errAdr;

    wb_splitter_n #(
        .NUM_SLAVES      (NSLV),
        .BASE_ADDR       (32'h3000_0000),
        .SLAVE_ADDR_SIZE (32'h0001_0000),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .ERR_DATA        (32'hDEAD_BEEF)
    ) dut (
        .wb_clk    (clk),
        .wb_rst    (rst),
        .wb_adr    (wbAdr),
        .wb_dat_i  (wbDatI),
        .wb_sel    (wbSel),
        .wb_we     (wbWe),
        .wb_stb    (wbStb),
        .wb_cyc    (wbCyc),
        .wb_dat_o  (wbDatO),
        .wb_ack    (wbAck),
        .s_adr     (sAdr),
        .s_dat_o   (sDatO),
        .s_sel     (sSel),
        .s_we      (sWe),
        .s_stb     (sStb),
        .s_cyc     (sCyc),
        .s_dat_i   (sDatI),
        .s_ack     (sAck),
        .err_pulse (errPulse),
        .err_adr   (errAdr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int ackCount   = 0;
    int errCount   = 0;

    logic [31:0] expQ[$];

    // Slave models: ack after ackWait[i] cycles of strobe (-1 = never), plus a spurious-ack override.
    int              ackWait  [NSLV];
    int              waitCnt  [NSLV];
    logic [31:0]     slvData  [NSLV];
    logic [NSLV-1:0] spurious;

    always @(posedge clk) begin
        for (int i = 0; i < NSLV; i++) begin
            if (!sStb[i]) waitCnt[i] <= 0;
            else          waitCnt[i] <= waitCnt[i] + 1;
        end
    end

    always_comb begin
        sAck  = '0;
        sDatI = '0;
        for (int i = 0; i < NSLV; i++) begin
            sAck[i] = spurious[i] | (sStb[i] && ackWait[i] >= 0 && waitCnt[i] == ackWait[i]);
            sDatI[32*i +: 32] = slvData[i];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard consumer: every wb_ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (errPulse) errCount++;
        if (wbAck) begin
            ackCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedAck", {31'd0, wbAck}, 32'd0);
            end else begin
                checkOutput("rdata", wbDatO, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic we, input logic req);
        wbAdr  = adr;
        wbDatI = dat;
        wbSel  = sel;
        wbWe   = we;
        wbStb  = req;
        wbCyc  = req;
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          waits;
        logic [31:0] slvDat;
        int          expSlave;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    task automatic runTransaction(input vec_t v);
        logic [3:0]  expStb;
        int          expLat;
        int          n;
        logic        got;
        int          ackBefore;
        int          errBefore;
        expStb = (v.expSlave >= 0) ? (4'b0001 << v.expSlave) : 4'b0000;
        if (v.expSlave < 0)      expLat = 2;
        else if (v.waits < 0)    expLat = TIMEOUT + 2;
        else                     expLat = v.waits + 2;
        if (v.expSlave >= 0) begin
            ackWait[v.expSlave] = v.waits;
            slvData[v.expSlave] = v.slvDat;
        end
        ackBefore = ackCount;
        errBefore = errCount;
        expQ.push_back(v.expData);
        @(negedge clk);
        applyStimulus(v.adr, v.dat, v.sel, v.we, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("sStb", {28'd0, sStb}, {28'd0, expStb});
        checkOutput("sCyc", {28'd0, sCyc}, {28'd0, expStb});
        if (v.expSlave >= 0) begin
            checkOutput("sAdr", sAdr, v.adr);
            checkOutput("sDatO", sDatO, v.dat);
            checkOutput("sSel", {28'd0, sSel}, {28'd0, v.sel});
            checkOutput("sWe", {31'd0, sWe}, {31'd0, v.we});
        end
        got = 1'b0;
        n   = 1;
        @(negedge clk);
        while (!wbAck && n < 60) begin
            @(negedge clk);
            n++;
        end
        got = wbAck;
        checkOutput("ackSeen", {31'd0, got}, 32'd1);
        if (got) checkOutput("latency", n, expLat);
        else if (expQ.size() > 0) void'(expQ.pop_back());
        applyStimulus(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ackWidth", {31'd0, wbAck}, 32'd0);
        checkOutput("ackCount", ackCount - ackBefore, 32'd1);
        checkOutput("errPulses", errCount - errBefore, {31'd0, v.expErr});
        if (v.expErr) checkOutput("errAdr", errAdr, v.adr);
        checkOutput("sStbIdle", {28'd0, sStb}, 32'd0);
        if (v.expSlave >= 0) ackWait[v.expSlave] = -1;
    endtask

    vec_t vecs[7];
    vec_t tv;
    int   ackMark;
    int   errMark;

    initial begin
        for (int i = 0; i < NSLV; i++) begin
            ackWait[i] = -1;
            slvData[i] = 32'h5100_0000 + 32'(i);
        end
        spurious = '0;
        applyStimulus(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;

        vecs[0] = '{32'h3002_0010, 32'h0000_0000, 4'hF,    1'b0, 3, 32'h1234_5678,  2, 32'h1234_5678, 1'b0};
        vecs[1] = '{32'h3000_0004, 32'hA5A5_0001, 4'b0011, 1'b1, 1, 32'h0000_0077,  0, 32'h0000_0077, 1'b0};
        vecs[2] = '{32'h3004_0000, 32'h0000_0000, 4'hF,    1'b0, 0, 32'h0,         -1, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{32'h2FFF_FFFC, 32'h1111_2222, 4'hF,    1'b1, 0, 32'h0,         -1, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{32'h3003_FFFC, 32'h0000_0000, 4'hF,    1'b0, 0, 32'hCAFE_0003,  3, 32'hCAFE_0003, 1'b0};
        vecs[5] = '{32'h3000_0000, 32'h0000_0000, 4'hF,    1'b0, 0, 32'h0BAD_F00D,  0, 32'h0BAD_F00D, 1'b0};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'hF,    1'b0, 0, 32'h0,         -1, 32'hDEAD_BEEF, 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("rstAck", {31'd0, wbAck}, 32'd0);
        checkOutput("rstStb", {28'd0, sStb}, 32'd0);
        checkOutput("rstErr", {31'd0, errPulse}, 32'd0);
        checkOutput("rstDat", wbDatO, 32'd0);
        checkOutput("rstErrAdr", errAdr, 32'd0);
        checkOutput("rstSAdr", sAdr, 32'd0);
        rst = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            runTransaction(vecs[i]);
        end

`ifdef WB_SPLITTER_TIMEOUT_EN
        $display("[TB] timeout on silent slave 1");
        tv = '{32'h3001_0000, 32'h0, 4'hF, 1'b0, -1, 32'h0, 1, 32'hDEAD_BEEF, 1'b1};
        runTransaction(tv);
`else
        $display("[TB] silent slave 1 without timeout");
        ackMark = ackCount;
        errMark = errCount;
        @(negedge clk);
        applyStimulus(32'h3001_0000, 32'h0, 4'hF, 1'b0, 1'b1);
        repeat (1000) @(negedge clk);
        checkOutput("hangNoAck", ackCount - ackMark, 32'd0);
        checkOutput("hangStb", {28'd0, sStb}, 32'b0010);
        applyStimulus(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hangAbortStb", {28'd0, sStb}, 32'd0);
        checkOutput("hangNoErr", errCount - errMark, 32'd0);
`endif

        $display("[TB] master abort then window 3 with spurious ack");
        ackMark = ackCount;
        errMark = errCount;
        @(negedge clk);
        applyStimulus(32'h3001_0040, 32'h0, 4'hF, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("abortStbBefore", {28'd0, sStb}, 32'b0010);
        applyStimulus(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("abortStb", {28'd0, sStb}, 32'd0);
        checkOutput("abortNoAck", ackCount - ackMark, 32'd0);
        checkOutput("abortNoErr", errCount - errMark, 32'd0);
        spurious = 4'b0001;
        tv = '{32'h3003_0100, 32'h0, 4'hF, 1'b0, 2, 32'h3333_3333, 3, 32'h3333_3333, 1'b0};
        runTransaction(tv);
        spurious = '0;

        $display("[TB] reset during BUSY");
        ackMark = ackCount;
        @(negedge clk);
        applyStimulus(32'h3002_0000, 32'h0, 4'hF, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("preRstStb", {28'd0, sStb}, 32'b0100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstStb", {28'd0, sStb}, 32'd0);
        checkOutput("midRstAck", {31'd0, wbAck}, 32'd0);
        checkOutput("midRstErr", {31'd0, errPulse}, 32'd0);
        applyStimulus(32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstNoAck", ackCount - ackMark, 32'd0);
        tv = '{32'h3002_0020, 32'h0, 4'hF, 1'b0, 0, 32'h7777_0002, 2, 32'h7777_0002, 1'b0};
        runTransaction(tv);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
